// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: shares the instruction-memory port between CPU fetch and the UART loader,
// sequencing RUN -> DRAIN -> LOAD -> FLUSH with word count, watchdog and sticky error.
`default_nettype none

module imem_load_arbiter #(
   parameter int ADDR_W       = 14,
   parameter int DEPTH        = 16384,
   parameter int FLUSH_CYCLES = 4,
   parameter int WDOG_CYCLES  = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpu_adr_i,
   input  logic              upg_start_i,
   input  logic              upg_wen_i,
   input  logic [ADDR_W-1:0] upg_adr_i,
   input  logic [31:0]       upg_dat_i,
   input  logic              upg_done_i,
   output logic [ADDR_W-1:0] mem_adr_o,
   output logic [31:0]       mem_dat_o,
   output logic              mem_wen_o,
   output logic              cpu_stall_o,
   output logic              cpu_rst_o,
   output logic [ADDR_W:0]   words_o,
   output logic              err_o
);

   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
   localparam int FL_W   = $clog2(FLUSH_CYCLES + 1);
   localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] DEPTH_V   = (ADDR_W+1)'(DEPTH);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
   localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      LOAD  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   words_q, words_d;
   logic              err_q, err_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic [FL_W-1:0]   flush_q, flush_d;
   logic              rst_hold_q;
   logic              in_range;

   assign in_range = {1'b0, upg_adr_i} < DEPTH_V;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         words_q    <= '0;
         err_q      <= 1'b0;
         wdog_q     <= '0;
         flush_q    <= '0;
         rst_hold_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         words_q    <= words_d;
         err_q      <= err_d;
         wdog_q     <= wdog_d;
         flush_q    <= flush_d;
         rst_hold_q <= 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      words_d     = words_q;
      err_d       = err_q;
      wdog_d      = wdog_q;
      flush_d     = flush_q;
      mem_adr_o   = cpu_adr_i;
      mem_dat_o   = upg_dat_i;
      mem_wen_o   = 1'b0;
      cpu_stall_o = 1'b1;
      cpu_rst_o   = rst_hold_q;

      case (state_q)
         RUN: begin
            cpu_stall_o = 1'b0;
            if (upg_start_i) begin
               state_d = DRAIN;
               words_d = '0;
               err_d   = 1'b0;
               wdog_d  = '0;
            end
         end
         DRAIN: begin
            state_d = LOAD;
         end
         LOAD: begin
            mem_adr_o = upg_adr_i;
            mem_wen_o = upg_wen_i & in_range & ~rst;
            if (upg_wen_i) begin
               wdog_d = '0;
               if (in_range) begin
                  if (words_q != WORDS_MAX) words_d = words_q + 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (wdog_q == WDOG_LAST) begin
               err_d = err_d | ~upg_done_i;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
            // done wins over a coincident watchdog expiry; both end the load
            if (upg_done_i || (!upg_wen_i && wdog_q == WDOG_LAST)) begin
               state_d = FLUSH;
               flush_d = FL_LAST;
            end
         end
         FLUSH: begin
            cpu_rst_o = 1'b1;
            if (flush_q == '0) state_d = RUN;
            else               flush_d = flush_q - 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   assign words_o = words_q;
   assign err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_load_arbiter.sv
// tb_imem_load_arbiter: directed scenario tasks with hand-computed expectations.
`default_nettype none

module tb_imem_load_arbiter;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 200;
   localparam int FLUSH_CYCLES = 4;
   localparam int WDOG_CYCLES  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] cpu_adr_i = '0;
   logic              upg_start_i = 1'b0;
   logic              upg_wen_i = 1'b0;
   logic [ADDR_W-1:0] upg_adr_i = '0;
   logic [31:0]       upg_dat_i = '0;
   logic              upg_done_i = 1'b0;
   logic [ADDR_W-1:0] mem_adr_o;
   logic [31:0]       mem_dat_o;
   logic              mem_wen_o;
   logic              cpu_stall_o;
   logic              cpu_rst_o;
   logic [ADDR_W:0]   words_o;
   logic              err_o;

   int checks = 0;
   int failures = 0;

   imem_load_arbiter #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH),
      .FLUSH_CYCLES(FLUSH_CYCLES), .WDOG_CYCLES(WDOG_CYCLES)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_adr_i(cpu_adr_i), .upg_start_i(upg_start_i), .upg_wen_i(upg_wen_i),
      .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i), .upg_done_i(upg_done_i),
      .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_wen_o(mem_wen_o),
      .cpu_stall_o(cpu_stall_o), .cpu_rst_o(cpu_rst_o),
      .words_o(words_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      settle();
      checks++; if (mem_wen_o !== 1'b0) begin failures++; $display("FAIL reset_wen got=%0b exp=0", mem_wen_o); end
      rst = 1'b0;
      settle();
      checks++; if (cpu_rst_o !== 1'b1) begin failures++; $display("FAIL reset_cpu_rst_hold got=%0b exp=1", cpu_rst_o); end
      checks++; if (words_o !== 9'd0) begin failures++; $display("FAIL reset_words got=%0d exp=0", words_o); end
      checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_o); end
      checks++; if (cpu_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", cpu_stall_o); end
      tick();
      checks++; if (cpu_rst_o !== 1'b0) begin failures++; $display("FAIL reset_cpu_rst_release got=%0b exp=0", cpu_rst_o); end
   endtask

   task automatic test_normal_load();
      int nwr;
      logic [31:0] dat [3];
      dat[0] = 32'hA0; dat[1] = 32'hB1; dat[2] = 32'hC2;
      nwr = 0;
      cpu_adr_i = 8'h33;
      upg_start_i = 1'b1;
      settle();
      checks++; if (cpu_stall_o !== 1'b0) begin failures++; $display("FAIL load_run_stall got=%0b exp=0", cpu_stall_o); end
      tick();
      upg_start_i = 1'b0;
      upg_wen_i = 1'b1; upg_adr_i = 8'd9;
      settle();
      checks++; if (cpu_stall_o !== 1'b1 || mem_wen_o !== 1'b0 || mem_adr_o !== 8'h33) begin
         failures++; $display("FAIL load_drain got stall=%0b wen=%0b adr=%0h exp 1 0 33", cpu_stall_o, mem_wen_o, mem_adr_o); end
      tick();
      for (int i = 0; i < 3; i++) begin
         upg_wen_i = 1'b1; upg_adr_i = ADDR_W'(i); upg_dat_i = dat[i];
         settle();
         if (mem_wen_o === 1'b1) nwr++;
         checks++; if (mem_adr_o !== ADDR_W'(i) || mem_dat_o !== dat[i]) begin
            failures++; $display("FAIL load_write_%0d got adr=%0h dat=%0h exp adr=%0h dat=%0h", i, mem_adr_o, mem_dat_o, i, dat[i]); end
         tick();
      end
      upg_wen_i = 1'b0; upg_done_i = 1'b1;
      settle();
      checks++; if (nwr !== 3) begin failures++; $display("FAIL load_write_count got=%0d exp=3", nwr); end
      checks++; if (words_o !== 9'd3) begin failures++; $display("FAIL load_words got=%0d exp=3", words_o); end
      tick();
      upg_done_i = 1'b0;
      for (int i = 0; i < FLUSH_CYCLES; i++) begin
         upg_wen_i = 1'b1; upg_adr_i = 8'd4;
         settle();
         checks++; if (cpu_rst_o !== 1'b1 || cpu_stall_o !== 1'b1 || mem_wen_o !== 1'b0) begin
            failures++; $display("FAIL load_flush_%0d got rst=%0b stall=%0b wen=%0b exp 1 1 0", i, cpu_rst_o, cpu_stall_o, mem_wen_o); end
         tick();
      end
      upg_wen_i = 1'b0;
      settle();
      checks++; if (cpu_rst_o !== 1'b0 || cpu_stall_o !== 1'b0 || mem_adr_o !== 8'h33 || words_o !== 9'd3) begin
         failures++; $display("FAIL load_back_run got rst=%0b stall=%0b adr=%0h words=%0d exp 0 0 33 3", cpu_rst_o, cpu_stall_o, mem_adr_o, words_o); end
   endtask

   task automatic test_out_of_range_and_done_wen();
      upg_start_i = 1'b1; tick(); upg_start_i = 1'b0; tick();
      upg_wen_i = 1'b1; upg_adr_i = 8'd3; tick();
      upg_adr_i = ADDR_W'(DEPTH);
      settle();
      checks++; if (mem_wen_o !== 1'b0) begin failures++; $display("FAIL oor_wen got=%0b exp=0", mem_wen_o); end
      tick();
      upg_wen_i = 1'b0;
      settle();
      checks++; if (words_o !== 9'd1 || err_o !== 1'b1) begin
         failures++; $display("FAIL oor_words_err got words=%0d err=%0b exp 1 1", words_o, err_o); end
      upg_done_i = 1'b1; tick(); upg_done_i = 1'b0;
      for (int i = 0; i < FLUSH_CYCLES; i++) tick();
      settle();
      checks++; if (err_o !== 1'b1 || cpu_stall_o !== 1'b0) begin
         failures++; $display("FAIL oor_sticky got err=%0b stall=%0b exp 1 0", err_o, cpu_stall_o); end
      upg_start_i = 1'b1; tick(); upg_start_i = 1'b0;
      settle();
      checks++; if (err_o !== 1'b0 || words_o !== 9'd0) begin
         failures++; $display("FAIL start_clears got err=%0b words=%0d exp 0 0", err_o, words_o); end
      tick();
      upg_wen_i = 1'b1; upg_done_i = 1'b1; upg_adr_i = 8'd5;
      settle();
      checks++; if (mem_wen_o !== 1'b1 || mem_adr_o !== 8'd5) begin
         failures++; $display("FAIL donewen_write got wen=%0b adr=%0h exp 1 5", mem_wen_o, mem_adr_o); end
      tick();
      upg_wen_i = 1'b0; upg_done_i = 1'b0;
      settle();
      checks++; if (words_o !== 9'd1 || cpu_rst_o !== 1'b1 || err_o !== 1'b0) begin
         failures++; $display("FAIL donewen_flush got words=%0d rst=%0b err=%0b exp 1 1 0", words_o, cpu_rst_o, err_o); end
      for (int i = 0; i < FLUSH_CYCLES; i++) tick();
   endtask

   task automatic test_watchdog();
      upg_start_i = 1'b1; tick(); upg_start_i = 1'b0; tick();
      for (int i = 1; i < WDOG_CYCLES; i++) tick();
      settle();
      checks++; if (cpu_rst_o !== 1'b0 || cpu_stall_o !== 1'b1 || err_o !== 1'b0) begin
         failures++; $display("FAIL wdog_last_load got rst=%0b stall=%0b err=%0b exp 0 1 0", cpu_rst_o, cpu_stall_o, err_o); end
      tick();
      checks++; if (cpu_rst_o !== 1'b1 || err_o !== 1'b1) begin
         failures++; $display("FAIL wdog_abort got rst=%0b err=%0b exp 1 1", cpu_rst_o, err_o); end
      for (int i = 0; i < FLUSH_CYCLES; i++) tick();
   endtask

   task automatic test_saturate();
      upg_start_i = 1'b1; tick(); upg_start_i = 1'b0; tick();
      upg_wen_i = 1'b1;
      for (int i = 0; i < 260; i++) begin
         upg_adr_i = ADDR_W'(i % 100);
         tick();
      end
      upg_wen_i = 1'b0;
      settle();
      checks++; if (words_o !== 9'd256 || err_o !== 1'b0) begin
         failures++; $display("FAIL saturate got words=%0d err=%0b exp 256 0", words_o, err_o); end
      upg_done_i = 1'b1; tick(); upg_done_i = 1'b0;
      for (int i = 0; i < FLUSH_CYCLES; i++) tick();
   endtask

   task automatic test_back_to_back();
      upg_start_i = 1'b1; tick(); tick();
      upg_done_i = 1'b1; tick(); upg_done_i = 1'b0;
      for (int i = 0; i < FLUSH_CYCLES; i++) tick();
      settle();
      checks++; if (cpu_stall_o !== 1'b0 || cpu_rst_o !== 1'b0) begin
         failures++; $display("FAIL b2b_run got stall=%0b rst=%0b exp 0 0", cpu_stall_o, cpu_rst_o); end
      tick();
      upg_start_i = 1'b0;
      settle();
      checks++; if (cpu_stall_o !== 1'b1 || cpu_rst_o !== 1'b0) begin
         failures++; $display("FAIL b2b_drain got stall=%0b rst=%0b exp 1 0", cpu_stall_o, cpu_rst_o); end
      tick();
      upg_done_i = 1'b1; tick(); upg_done_i = 1'b0;
      for (int i = 0; i < FLUSH_CYCLES; i++) tick();
   endtask

   task automatic test_stray_and_reset();
      upg_wen_i = 1'b1; upg_adr_i = 8'd7;
      settle();
      checks++; if (mem_wen_o !== 1'b0) begin failures++; $display("FAIL stray_run_wen got=%0b exp=0", mem_wen_o); end
      tick();
      checks++; if (words_o !== 9'd0) begin failures++; $display("FAIL stray_run_words got=%0d exp=0", words_o); end
      upg_wen_i = 1'b0;
      upg_start_i = 1'b1; tick(); upg_start_i = 1'b0; tick();
      upg_wen_i = 1'b1; upg_adr_i = 8'd9; rst = 1'b1;
      settle();
      checks++; if (mem_wen_o !== 1'b0) begin failures++; $display("FAIL rst_cycle_wen got=%0b exp=0", mem_wen_o); end
      tick();
      rst = 1'b0;
      settle();
      checks++; if (cpu_stall_o !== 1'b0 || mem_wen_o !== 1'b0 || cpu_rst_o !== 1'b1 || mem_adr_o !== cpu_adr_i) begin
         failures++; $display("FAIL rst_mid_load got stall=%0b wen=%0b rst=%0b adr=%0h exp 0 0 1 %0h", cpu_stall_o, mem_wen_o, cpu_rst_o, mem_adr_o, cpu_adr_i); end
      upg_wen_i = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_normal_load();
      test_out_of_range_and_done_wen();
      test_watchdog();
      test_saturate();
      test_back_to_back();
      test_stray_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
